// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write-back path.
package rf_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned RF_XLEN    = 32;

  // Requester slot assignment on the write-back arbiter.
  typedef enum logic [1:0] {
    REQ_ALU = 2'd0,
    REQ_LSU = 2'd1,
    REQ_MDU = 2'd2
  } req_idx_e;

  // Write-port bundle as seen by register_file.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [RF_XLEN-1:0]    data;
    logic                  we;
  } wb_port_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, last-grant pointer
// advanced only when the granted request actually transfers.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [N-1:0]                          req_i,
  input  logic                                  update_i,
  output logic [N-1:0]                          gnt_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]  idx_o
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] lg_q;
  logic [IDX_W-1:0] lg_d;
  logic [IDX_W-1:0] idx_s;
  logic             found_s;
  int               cand_s;

  // Search upward from the slot after the last grant, wrapping at N.
  always_comb begin
    found_s = 1'b0;
    idx_s   = {IDX_W{1'b0}};
    cand_s  = 0;
    gnt_o   = {N{1'b0}};
    for (int off = 1; off <= int'(N); off++) begin
      cand_s = int'(lg_q) + off;
      if (cand_s >= int'(N)) begin
        cand_s = cand_s - int'(N);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req_i[cand_s]) begin
        found_s = 1'b1;
        idx_s   = IDX_W'(cand_s);
      end else begin
        found_s = found_s;
      end
    end
    gnt_o[idx_s] = found_s;
    idx_o        = idx_s;
  end

  // Pointer moves to the winner only on a completed handshake.
  always_comb begin
    if (update_i && found_s) begin
      lg_d = idx_s;
    end else begin
      lg_d = lg_q;
    end
  end

  // Last-grant pointer; reset value gives slot 0 first priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lg_q <= IDX_W'(N - 1);
    end else begin
      lg_q <= lg_d;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the integer register file plus a pending-write
// scoreboard used by issue logic for RAW stalls.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_REQ = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*REG_ADDR_W-1:0]  req_rd_i,
  input  logic [NUM_REQ*XLEN-1:0]        req_data_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic                           issue_valid_i,
  input  logic [REG_ADDR_W-1:0]          issue_rd_i,
  output logic [REG_ADDR_W-1:0]          rd_o,
  output logic [XLEN-1:0]                rd_din_o,
  output logic                           reg_write_o,
  output logic [NUM_REGS-1:0]            busy_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    gnt_s;
  logic [IDX_W-1:0]      gnt_idx_s;
  logic                  xfer_s;
  logic [REG_ADDR_W-1:0] sel_rd_s;
  logic [XLEN-1:0]       sel_data_s;

  logic [REG_ADDR_W-1:0] rd_q,   rd_d;
  logic [XLEN-1:0]       din_q,  din_d;
  logic                  we_q,   we_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req_valid_i),
    .update_i (xfer_s),
    .gnt_o    (gnt_s),
    .idx_o    (gnt_idx_s)
  );

  // Grants are suppressed while reset is held; a grant is always a transfer.
  always_comb begin
    req_ready_o = gnt_s & {NUM_REQ{rst_ni}};
    xfer_s      = |(req_valid_i & req_ready_o);
  end

  // One-hot AND-OR mux of the winner's destination and data.
  always_comb begin
    sel_rd_s   = {REG_ADDR_W{1'b0}};
    sel_data_s = {XLEN{1'b0}};
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      sel_rd_s   = sel_rd_s   | ({REG_ADDR_W{req_ready_o[k]}} & req_rd_i[k*REG_ADDR_W +: REG_ADDR_W]);
      sel_data_s = sel_data_s | ({XLEN{req_ready_o[k]}} & req_data_i[k*XLEN +: XLEN]);
    end
  end

  // Next write-port contents: load on transfer, otherwise hold rd/data and drop we.
  always_comb begin
    if (xfer_s) begin
      rd_d  = sel_rd_s;
      din_d = sel_data_s;
      we_d  = (sel_rd_s != {REG_ADDR_W{1'b0}});
    end else begin
      rd_d  = rd_q;
      din_d = din_q;
      we_d  = 1'b0;
    end
  end

  // Scoreboard: clear on transfer first so a same-cycle issue to that register wins.
  always_comb begin
    busy_d = busy_q;
    if (xfer_s) begin
      busy_d[sel_rd_s] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (issue_valid_i && (issue_rd_i != {REG_ADDR_W{1'b0}})) begin
      busy_d[issue_rd_i] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // Registered write port and scoreboard state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q   <= {REG_ADDR_W{1'b0}};
      din_q  <= {XLEN{1'b0}};
      we_q   <= 1'b0;
      busy_q <= {NUM_REGS{1'b0}};
    end else begin
      rd_q   <= rd_d;
      din_q  <= din_d;
      we_q   <= we_d;
      busy_q <= busy_d;
    end
  end

  assign rd_o        = rd_q;
  assign rd_din_o    = din_q;
  assign reg_write_o = we_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  localparam int XLEN = 32;
  localparam int NREQ = 3;

  logic              clk;
  logic              rst_ni;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*5-1:0] req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              issue_valid;
  logic [4:0]        issue_rd;
  logic [4:0]        rd_o;
  logic [XLEN-1:0]   rd_din_o;
  logic              reg_write_o;
  logic [31:0]       busy_o;

  int tests_run;
  int tests_failed;

  rf_wb_arbiter #(.XLEN(XLEN), .NUM_REQ(NREQ)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid),
    .req_rd_i      (req_rd),
    .req_data_i    (req_data),
    .req_ready_o   (req_ready),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .rd_o          (rd_o),
    .rd_din_o      (rd_din_o),
    .reg_write_o   (reg_write_o),
    .busy_o        (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid   = 3'b000;
    req_rd      = 15'd0;
    req_data    = {NREQ*XLEN{1'b0}};
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    req_valid = 3'b111;
    rst_ni = 1'b0;
    #2;
    tests_run++;
    if (req_ready !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b want 000", req_ready);
    end
    step();
    tests_run++;
    if (reg_write_o !== 1'b0 || rd_o !== 5'd0 || rd_din_o !== 32'd0 || busy_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: we=%b rd=%0d din=%h busy=%h want all zero",
               reg_write_o, rd_o, rd_din_o, busy_o);
    end
    req_valid = 3'b000;
    rst_ni = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      tests_run++;
      if (reg_write_o !== 1'b0 || busy_o !== 32'd0 || rd_o !== 5'd0 || req_ready !== 3'b000) begin
        tests_failed++;
        $display("FAIL idle_after_reset cycle %0d: we=%b busy=%h rd=%0d ready=%b want 0",
                 i, reg_write_o, busy_o, rd_o, req_ready);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_gnt;
    logic [4:0]  exp_rd;
    logic [31:0] exp_din;
    req_rd    = {5'd3, 5'd2, 5'd1};
    req_data  = {32'hC, 32'hB, 32'hA};
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      exp_gnt = 3'b001 << (i % 3);
      exp_rd  = 5'(i % 3 + 1);
      exp_din = 32'(32'hA + (i % 3));
      #1;
      tests_run++;
      if (req_ready !== exp_gnt) begin
        tests_failed++;
        $display("FAIL rr_grant step %0d: got %b want %b", i, req_ready, exp_gnt);
      end
      step();
      tests_run++;
      if (reg_write_o !== 1'b1 || rd_o !== exp_rd || rd_din_o !== exp_din) begin
        tests_failed++;
        $display("FAIL rr_write step %0d: we=%b rd=%0d din=%h want we=1 rd=%0d din=%h",
                 i, reg_write_o, rd_o, rd_din_o, exp_rd, exp_din);
      end
    end
    req_valid = 3'b000;
    step();
    tests_run++;
    if (reg_write_o !== 1'b0 || rd_o !== 5'd3 || rd_din_o !== 32'hC || busy_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL rr_hold: we=%b rd=%0d din=%h busy=%h want we=0 rd=3 din=c busy=0",
               reg_write_o, rd_o, rd_din_o, busy_o);
    end
  endtask

  task automatic test_busy_lsu();
    idle_inputs();
    issue_valid = 1'b1;
    issue_rd    = 5'd5;
    step();
    issue_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      tests_run++;
      if (busy_o !== 32'h0000_0020) begin
        tests_failed++;
        $display("FAIL busy_pending cycle %0d: got %h want 00000020", c, busy_o);
      end
      step();
    end
    req_valid = 3'b001 << REQ_LSU;
    req_rd    = {5'd0, 5'd5, 5'd0};
    req_data  = {32'h0, 32'hDEADBEEF, 32'h0};
    #1;
    tests_run++;
    if (busy_o !== 32'h0000_0020 || req_ready !== 3'b010) begin
      tests_failed++;
      $display("FAIL busy_lsu_cycle3: busy=%h ready=%b want busy=00000020 ready=010", busy_o, req_ready);
    end
    step();
    req_valid = 3'b000;
    tests_run++;
    if (busy_o !== 32'd0 || reg_write_o !== 1'b1 || rd_o !== 5'd5 || rd_din_o !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL busy_lsu_cycle4: busy=%h we=%b rd=%0d din=%h want busy=0 we=1 rd=5 din=deadbeef",
               busy_o, reg_write_o, rd_o, rd_din_o);
    end
  endtask

  task automatic test_set_clear_same();
    idle_inputs();
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    step();
    req_valid = 3'b001;
    req_rd    = {5'd0, 5'd0, 5'd7};
    req_data  = {32'h0, 32'h0, 32'h77};
    #1;
    tests_run++;
    if (req_ready !== 3'b001) begin
      tests_failed++;
      $display("FAIL same_cycle_grant: got %b want 001", req_ready);
    end
    step();
    issue_valid = 1'b0;
    tests_run++;
    if (busy_o !== 32'h0000_0080 || reg_write_o !== 1'b1 || rd_o !== 5'd7 || rd_din_o !== 32'h77) begin
      tests_failed++;
      $display("FAIL set_wins: busy=%h we=%b rd=%0d din=%h want busy=00000080 we=1 rd=7 din=77",
               busy_o, reg_write_o, rd_o, rd_din_o);
    end
    req_data = {32'h0, 32'h0, 32'h78};
    step();
    req_valid = 3'b000;
    tests_run++;
    if (busy_o !== 32'd0 || reg_write_o !== 1'b1 || rd_din_o !== 32'h78) begin
      tests_failed++;
      $display("FAIL waw_clear: busy=%h we=%b din=%h want busy=0 we=1 din=78",
               busy_o, reg_write_o, rd_din_o);
    end
  endtask

  task automatic test_rd_zero();
    idle_inputs();
    req_valid = 3'b100;
    req_rd    = {5'd0, 5'd0, 5'd0};
    req_data  = {32'h1234, 32'h0, 32'h0};
    #1;
    tests_run++;
    if (req_ready !== 3'b100) begin
      tests_failed++;
      $display("FAIL rd0_ready: got %b want 100", req_ready);
    end
    step();
    req_valid = 3'b000;
    tests_run++;
    if (reg_write_o !== 1'b0 || busy_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL rd0_no_write: we=%b busy=%h want we=0 busy=0", reg_write_o, busy_o);
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    issue_valid = 1'b1;
    for (int r = 4; r <= 7; r++) begin
      issue_rd = 5'(r);
      step();
    end
    issue_valid = 1'b0;
    req_valid = 3'b010;
    req_rd    = {5'd0, 5'd9, 5'd0};
    req_data  = {32'h0, 32'h99, 32'h0};
    #1;
    tests_run++;
    if (req_ready !== 3'b010) begin
      tests_failed++;
      $display("FAIL mid_pre_grant: got %b want 010", req_ready);
    end
    step();
    tests_run++;
    if (busy_o !== 32'h0000_00F0 || reg_write_o !== 1'b1 || rd_o !== 5'd9) begin
      tests_failed++;
      $display("FAIL mid_pre_state: busy=%h we=%b rd=%0d want busy=000000f0 we=1 rd=9",
               busy_o, reg_write_o, rd_o);
    end
    req_valid = 3'b111;
    req_rd    = {5'd3, 5'd2, 5'd1};
    rst_ni = 1'b0;
    #1;
    tests_run++;
    if (busy_o !== 32'd0 || reg_write_o !== 1'b0 || rd_o !== 5'd0 || rd_din_o !== 32'd0 || req_ready !== 3'b000) begin
      tests_failed++;
      $display("FAIL mid_reset_clear: busy=%h we=%b rd=%0d din=%h ready=%b want all zero",
               busy_o, reg_write_o, rd_o, rd_din_o, req_ready);
    end
    step();
    rst_ni = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 3'b001) begin
      tests_failed++;
      $display("FAIL post_reset_grant: got %b want 001", req_ready);
    end
    step();
    req_valid = 3'b000;
    tests_run++;
    if (reg_write_o !== 1'b1 || rd_o !== 5'd1) begin
      tests_failed++;
      $display("FAIL post_reset_write: we=%b rd=%0d want we=1 rd=1", reg_write_o, rd_o);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_ni       = 1'b1;
    idle_inputs();
    #3;
    test_reset();
    test_round_robin();
    test_busy_lsu();
    test_set_clear_same();
    test_rd_zero();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and pending-write scoreboard for the core's 32-entry integer register file. It shares the register file's single write port (`rd_i`, `rd_din_i`, `reg_write_i`) among NUM_REQ producers (ALU, LSU, MDU) using round-robin valid/ready handshakes. It presents one registered write per cycle and tracks which architectural registers have an outstanding producer, so issue logic can stall on RAW hazards. It sits between the execute-stage units and `register_file`.

## Interface
Parameters:
- XLEN, 32, data width
- NUM_REQ, 3, number of write-back requesters (index 0 = ALU, 1 = LSU, 2 = MDU); legal range is 2..8

Ports:
- clk_i  in  1  core clock, rising edge
- rst_ni  in  1  reset; asynchronous assert, active-low
- req_valid_i  in  NUM_REQ  requester k holds a result
- req_rd_i  in  NUM_REQ*5  destination of requester k, in bits [5k+4:5k]
- req_data_i  in  NUM_REQ*XLEN  result of requester k, in bits [XLEN*k+XLEN-1:XLEN*k]
- req_ready_o  out  NUM_REQ  one-hot or zero; requester k is granted this cycle
- issue_valid_i  in  1  an instruction writing issue_rd_i is dispatched this cycle
- issue_rd_i  in  5  destination of the dispatched instruction
- rd_o  out  5  to register_file rd_i
- rd_din_o  out  XLEN  to register_file rd_din_i
- reg_write_o  out  1  to register_file reg_write_i
- busy_o  out  32  bit r = 1 means register r has a pending write; bit 0 is always 0

## Operation
- Arbitration is round-robin. A last-grant pointer `lg` is held. Candidates are searched from (lg+1) mod NUM_REQ upward with wrap-around. The first requester with valid set wins.
- The grant is combinational: req_ready_o[k] = 1 in the same cycle as req_valid_i[k] when k wins. A transfer is valid && ready.
- `lg` updates to the winner only on a transfer. With no valid requests, `lg` holds.
- At most one transfer occurs per cycle. Losers keep valid asserted and hold rd/data stable. Ready is not required to be sticky.
- Transfer of (rd, data) from the winner:
  - rd_o <= rd and rd_din_o <= data on the next edge.
  - reg_write_o <= (rd != 0).
  - For rd = 0, the handshake completes, but no write is issued and busy is unchanged.
- With no transfer, reg_write_o <= 0. rd_o and rd_din_o hold their previous values.
- Scoreboard, evaluated per edge:
  - Clear busy[rd] on transfer.
  - Set busy[issue_rd_i] when issue_valid_i is high and issue_rd_i != 0.
  - When set and clear target the same register in the same cycle, set wins, because a new producer supersedes the old one.
- Issuing to an already-busy register is legal (WAW). Busy stays 1 and the first transfer to that register clears it. Issue logic must avoid WAW if it relies on busy.

## Timing
- Reset (async, rst_ni = 0):
  - reg_write_o = 0, rd_o = 0, rd_din_o = 0, busy_o = 0.
  - `lg` = NUM_REQ-1, so requester 0 has first priority after reset.
  - req_ready_o = 0 while in reset.
- Latency: a transfer in cycle T produces reg_write_o = 1 in cycle T+1. The register file commits at the end of T+1.
- busy[rd] falls in cycle T+1, the same cycle the write is on the port. The register_file same-cycle bypass returns rd_din_o to readers in T+1, so no extra stall cycle is needed.
- Throughput: one write per cycle, sustained. N continuously valid requesters each receive one grant every N cycles.
- Reset asserted mid-operation: the pending registered write is dropped and all busy bits are cleared. Issue logic must flush the pipeline together with reset.

## Structure
- Package `rf_pkg` holds:
  - REG_ADDR_W = 5 and NUM_REGS = 32.
  - An enum for requester indices (REQ_ALU, REQ_LSU, REQ_MDU).
  - A typedef for the write-port bundle {rd, data, we}.
- The natural sub-module is `rr_arbiter` (parameter N). Inputs are the request vector and a transfer-qualified update. Outputs are the one-hot grant and the binary index. The pointer register lives inside it.
- Top-level logic: grant mux, output registers, and the 32-bit scoreboard.

## Test plan
- Reset, then reset release with no requests: all outputs 0, busy_o = 0, no reg_write_o for 10 cycles.
- All three requesters valid continuously, rd = 1/2/3, data = 0xA/0xB/0xC: grants go 0,1,2,0,… Writes appear one cycle later in order (1,0xA), (2,0xB), (3,0xC).
- Issue rd = 5 in cycle 0, then LSU returns rd = 5, data = 0xDEADBEEF in cycle 3: busy_o[5] = 1 during cycles 1–3. In cycle 4, busy_o[5] = 0 and reg_write_o = 1 with rd_o = 5.
- Issue rd = 7 in the same cycle as an ALU transfer to rd = 7: busy_o[7] stays 1 and the write still appears the next cycle.
- A requester with rd = 0 and data = 0x1234: ready is asserted, reg_write_o stays 0, and busy_o[0] stays 0.
- Assert rst_ni low for one cycle while busy = 0x0000_00F0 and a write is registered: outputs and busy clear immediately, and the next grant goes to requester 0.
